fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 5 +
 rtl/fifo.sv | 74 +++++++
 tb/tb_fifo.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants.
// Default depth used by datapath input buffers.
package fifo_pkg;
  localparam int FIFO_SLOTS = 4;
endpackage

// File: rtl/fifo.sv
// Single-clock FIFO, first-word fall-through read,
// full/almost_full/empty decoded from the occupancy counter.
module fifo
  import fifo_pkg::*;
#(
  parameter int NUM_SLOTS     = FIFO_SLOTS,
  parameter int LOG_NUM_SLOTS = 2,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);

  localparam logic [LOG_NUM_SLOTS:0] CNT_FULL =
    (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
  localparam logic [LOG_NUM_SLOTS:0] CNT_AF =
    (LOG_NUM_SLOTS+1)'(NUM_SLOTS-1);
  localparam logic [LOG_NUM_SLOTS-1:0] PTR_LAST =
    LOG_NUM_SLOTS'(NUM_SLOTS-1);

  logic [DATA_WIDTH-1:0]    mem [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] rptr;
  logic [LOG_NUM_SLOTS-1:0] wptr;
  logic [LOG_NUM_SLOTS:0]   count;
  logic                     push;
  logic                     pop;

  assign empty       = (count == '0);
  assign full        = (count == CNT_FULL);
  assign almost_full = (count == CNT_AF);

  assign push = write & ~full;
  assign pop  = next_read & ~empty;

  assign data_read = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data_write;
  end

  // Explicit wrap compare keeps non-power-of-two depths legal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  cover property (@(posedge clk) disable iff (rst)
    write && full);
  cover property (@(posedge clk) disable iff (rst)
    next_read && empty);
  assert property (@(posedge clk) disable iff (rst)
    count <= CNT_FULL);
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo
// (4 slots x 32 bits).
module tb_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_write;
  logic        write;
  logic        full;
  logic        almost_full;
  logic [31:0] data_read;
  logic        next_read;
  logic        empty;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo #(
    .NUM_SLOTS(4),
    .LOG_NUM_SLOTS(2),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_write(data_write),
    .write(write),
    .full(full),
    .almost_full(almost_full),
    .data_read(data_read),
    .next_read(next_read),
    .empty(empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] v);
    write = 1'b1;
    data_write = v;
    tick();
    write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    write = 1'b0;
    next_read = 1'b0;
    data_write = '0;
    tick();
    n_chk++;
    if ({empty, full, almost_full} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got e/f/af=%b want 100",
               {empty, full, almost_full});
    end
    rst = 1'b0;
    tick();
    push_one(32'h11);
    push_one(32'h22);
    n_chk++;
    if (empty !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_rst_empty: got %b want 0", empty);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({empty, full, almost_full} !== 3'b100) begin
      n_fail++;
      $display("FAIL midrst_flags: got e/f/af=%b want 100",
               {empty, full, almost_full});
    end
    tick();
    rst = 1'b0;
    push_one(32'hA5A5A5A5);
    n_chk++;
    if (empty !== 1'b0 || data_read !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL post_rst_read: got e=%b d=%h want 0 a5a5a5a5",
               empty, data_read);
    end
    next_read = 1'b1;
    tick();
    next_read = 1'b0;
    n_chk++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_drain: got empty=%b want 1", empty);
    end
  endtask

  task automatic test_fill_drain();
    logic [2:0] exp_flags [4];
    exp_flags[0] = 3'b000;
    exp_flags[1] = 3'b000;
    exp_flags[2] = 3'b001;
    exp_flags[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      push_one(32'(i + 1));
      n_chk++;
      if ({empty, full, almost_full} !== exp_flags[i]) begin
        n_fail++;
        $display("FAIL fill_flags%0d: got e/f/af=%b want %b",
                 i + 1, {empty, full, almost_full}, exp_flags[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (data_read !== 32'(i + 1) || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL drain%0d: got e=%b d=%0d want 0 %0d",
                 i, empty, data_read, i + 1);
      end
      next_read = 1'b1;
      tick();
    end
    next_read = 1'b0;
    n_chk++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: got %b want 1", empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) push_one(32'(i));
    push_one(32'd9);
    n_chk++;
    if (full !== 1'b1 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full: got f=%b af=%b want 1 0",
               full, almost_full);
    end
    for (int i = 1; i <= 4; i++) begin
      n_chk++;
      if (data_read !== 32'(i) || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: got e=%b d=%0d want 0 %0d",
                 i, empty, data_read, i);
      end
      next_read = 1'b1;
      tick();
    end
    next_read = 1'b0;
    n_chk++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_empty: got %b want 1", empty);
    end
  endtask

  task automatic test_underflow();
    next_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({empty, full, almost_full} !== 3'b100) begin
        n_fail++;
        $display("FAIL udf_flags%0d: got e/f/af=%b want 100",
                 i, {empty, full, almost_full});
      end
    end
    next_read = 1'b0;
    push_one(32'd7);
    n_chk++;
    if (data_read !== 32'd7 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_read: got e=%b d=%0d want 0 7",
               empty, data_read);
    end
    next_read = 1'b1;
    tick();
    next_read = 1'b0;
    n_chk++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL udf_after: got empty=%b want 1", empty);
    end
  endtask

  task automatic test_simultaneous();
    push_one(32'd5);
    push_one(32'd6);
    write = 1'b1;
    data_write = 32'd8;
    next_read = 1'b1;
    tick();
    write = 1'b0;
    n_chk++;
    if (data_read !== 32'd6 || {empty, full, almost_full} !== 3'b000) begin
      n_fail++;
      $display("FAIL sim_mid: got d=%0d e/f/af=%b want 6 000",
               data_read, {empty, full, almost_full});
    end
    tick();
    n_chk++;
    if (data_read !== 32'd8 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_mid2: got e=%b d=%0d want 0 8",
               empty, data_read);
    end
    tick();
    next_read = 1'b0;
    n_chk++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_mid_cnt: got empty=%b want 1", empty);
    end
    write = 1'b1;
    data_write = 32'd3;
    next_read = 1'b1;
    tick();
    write = 1'b0;
    next_read = 1'b0;
    n_chk++;
    if (data_read !== 32'd3 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_empty: got e=%b d=%0d want 0 3",
               empty, data_read);
    end
    next_read = 1'b1;
    tick();
    next_read = 1'b0;
    n_chk++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_empty_cnt: got empty=%b want 1", empty);
    end
    for (int i = 1; i <= 4; i++) push_one(32'(i));
    write = 1'b1;
    data_write = 32'd9;
    next_read = 1'b1;
    tick();
    write = 1'b0;
    n_chk++;
    if ({full, almost_full} !== 2'b01 || data_read !== 32'd2) begin
      n_fail++;
      $display("FAIL sim_full: got f/af=%b d=%0d want 01 2",
               {full, almost_full}, data_read);
    end
    for (int i = 2; i <= 4; i++) begin
      n_chk++;
      if (data_read !== 32'(i) || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL sim_full_drain%0d: got e=%b d=%0d want 0 %0d",
                 i, empty, data_read, i);
      end
      tick();
    end
    next_read = 1'b0;
    n_chk++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_full_lost: got empty=%b want 1", empty);
    end
  endtask

  task automatic test_wrap();
    int in_idx  = 0;
    int out_idx = 0;
    int cycles  = 0;
    while (out_idx < 20 && cycles < 200) begin
      write = (in_idx < 20) && !full && !almost_full;
      data_write = 32'(in_idx);
      next_read = !empty;
      if (!empty) begin
        n_chk++;
        if (data_read !== 32'(out_idx)) begin
          n_fail++;
          $display("FAIL wrap_data%0d: got %0d want %0d",
                   out_idx, data_read, out_idx);
        end
        out_idx++;
      end
      if (write) in_idx++;
      tick();
      cycles++;
    end
    write = 1'b0;
    next_read = 1'b0;
    n_chk++;
    if (out_idx != 20 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_done: got out=%0d e=%b want 20 1",
               out_idx, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
